// File: rtl/accumulator_sched.sv
// ---------------------------------------------------------------------------
// accumulator_sched
//
// Round-robin scheduler that time-shares one accumulator (WIDTH lanes,
// VARWIDTH bits, LAYERS-deep adder tree) among NREQ requesters. One
// requester is granted at a time. Its operand vector is registered onto
// acc_vals, and the accumulator is driven through a one-cycle clear and
// then a run phase. The scheduler waits for acc_rdy and returns the sum
// tagged with the requester index.
//
// Build option:
//   ACC_SCHED_WATCHDOG_EN  When defined, a RUN-phase watchdog aborts an
//                          operation after TIMEOUT cycles without acc_rdy.
//                          The abort reports err=1 and sum=0. When the
//                          macro is undefined, RUN waits indefinitely and
//                          err is tied to 0.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   IDW       requester index width, ceil(log2(NREQ))
//   WIDTH     accumulator lane count (must equal 2**LAYERS)
//   LAYERS    accumulator adder-tree depth
//   VARWIDTH  operand / sum width
//   TIMEOUT   RUN cycles before abort (watchdog builds only)
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous reset, active low
//   req       per-requester level request, held until served
//   vals      packed operand vectors, requester k in slice k
//   grant     one-hot, requester currently being served
//   busy      high in every state except IDLE
//   done      one-cycle result strobe
//   done_id   served requester index, valid with done
//   sum       result, valid with done, held until the next done
//   err       operation aborted by the watchdog, valid with done
//   acc_en    accumulator enable
//   acc_rst   accumulator reset (active high, asynchronous at the target)
//   acc_vals  registered copy of the granted operand vector
//   acc_rdy   accumulator result ready
//   acc_sum   accumulator result
// ---------------------------------------------------------------------------
module accumulator_sched #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int WIDTH    = 16,
  parameter int LAYERS   = 4,
  parameter int VARWIDTH = 32,
  parameter int TIMEOUT  = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*WIDTH*VARWIDTH-1:0] vals,
  output logic [NREQ-1:0]                grant,
  output logic                           busy,
  output logic                           done,
  output logic [IDW-1:0]                 done_id,
  output logic [VARWIDTH-1:0]            sum,
  output logic                           err,
  output logic                           acc_en,
  output logic                           acc_rst,
  output logic [WIDTH*VARWIDTH-1:0]      acc_vals,
  input  logic                           acc_rdy,
  input  logic [VARWIDTH-1:0]            acc_sum
);

  // -------------------------------------------------------------------------
  // Elaboration-time configuration checks
  // -------------------------------------------------------------------------
  if (WIDTH != (1 << LAYERS)) begin : g_bad_layers
    $error("accumulator_sched: WIDTH must equal 2**LAYERS");
  end
  if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
    $error("accumulator_sched: NREQ must be in 2..8");
  end
  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("accumulator_sched: IDW must equal ceil(log2(NREQ))");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("accumulator_sched: TIMEOUT must be at least 1");
  end

  localparam int LANE_BITS = WIDTH * VARWIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // -------------------------------------------------------------------------
  // State and next-state signals
  // -------------------------------------------------------------------------
  logic [1:0]           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;    // last served requester
  logic [IDW-1:0]       idx_q, idx_d;    // requester being served
  logic [NREQ-1:0]      grant_d;
  logic                 busy_d;
  logic                 done_d;
  logic [IDW-1:0]       done_id_d;
  logic [VARWIDTH-1:0]  sum_d;
  logic                 acc_en_d;
  logic                 acc_rst_d;
  logic [LANE_BITS-1:0] acc_vals_d;

`ifdef ACC_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0]       wd_cnt_q, wd_cnt_d;
  logic                 err_d;
`endif

  // -------------------------------------------------------------------------
  // Operand vectors viewed as one slice per requester
  // -------------------------------------------------------------------------
  logic [LANE_BITS-1:0] vals_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign vals_arr[k] = vals[k*LANE_BITS +: LANE_BITS];
  end

  // -------------------------------------------------------------------------
  // Round-robin pick: first set request searching upward from ptr+1,
  // wrapping modulo NREQ. The modulo keeps non-power-of-two NREQ correct.
  // -------------------------------------------------------------------------
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // before any branch, so no path leaves it unassigned and no latch forms.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_idx = IDW'((int'(ptr_q) + i) % NREQ);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic. Every output is registered, so the
  // values a state presents are computed on the edge that enters it.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    grant_d    = grant;
    busy_d     = busy;
    done_d     = 1'b0;
    done_id_d  = done_id;
    sum_d      = sum;
    acc_en_d   = acc_en;
    acc_rst_d  = 1'b0;
    acc_vals_d = acc_vals;
`ifdef ACC_SCHED_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        grant_d  = '0;
        busy_d   = 1'b0;
        acc_en_d = 1'b0;
        if (pick_valid) begin
          // Capture the operand slice now. acc_vals then stays put from
          // CLEAR through DONE even if the requester changes its vector.
          state_d    = ST_CLEAR;
          idx_d      = pick_idx;
          grant_d    = NREQ'(1) << pick_idx;
          acc_vals_d = vals_arr[pick_idx];
          busy_d     = 1'b1;
          acc_rst_d  = 1'b1;
        end
      end

      ST_CLEAR: begin
        // acc_rst falls back to its default of 0 here: a single-cycle pulse.
        state_d  = ST_RUN;
        acc_en_d = 1'b1;
`ifdef ACC_SCHED_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end

      ST_RUN: begin
        if (acc_rdy) begin
          state_d   = ST_DONE;
          sum_d     = acc_sum;
          done_d    = 1'b1;
          done_id_d = idx_q;
          grant_d   = '0;
          acc_en_d  = 1'b0;
        end
`ifdef ACC_SCHED_WATCHDOG_EN
        // wd_cnt_q holds the number of completed RUN cycles before this
        // one. When it shows TIMEOUT-1, this is the TIMEOUT-th cycle
        // without acc_rdy. The accumulator is left as is; the next
        // operation's CLEAR pulse brings it back.
        else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          sum_d     = '0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          done_id_d = idx_q;
          grant_d   = '0;
          acc_en_d  = 1'b0;
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = idx_q;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers. The reset is synchronous, and acc_rst is held high for as
  // long as rst is low.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of
    // statement order.
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IDW'(NREQ - 1);
      idx_q    <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= '0;
      sum      <= '0;
      acc_en   <= 1'b0;
      acc_rst  <= 1'b1;
      acc_vals <= '0;
`ifdef ACC_SCHED_WATCHDOG_EN
      wd_cnt_q <= '0;
      err      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant    <= grant_d;
      busy     <= busy_d;
      done     <= done_d;
      done_id  <= done_id_d;
      sum      <= sum_d;
      acc_en   <= acc_en_d;
      acc_rst  <= acc_rst_d;
      acc_vals <= acc_vals_d;
`ifdef ACC_SCHED_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
      err      <= err_d;
`endif
    end
  end

`ifndef ACC_SCHED_WATCHDOG_EN
  // Without the watchdog nothing can abort, so err is constant.
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_sched.sv
// ---------------------------------------------------------------------------
// tb_accumulator_sched
//
// Directed bench for accumulator_sched. A behavioural accumulator stands in
// for the shared datapath. It clears on acc_rst, counts enabled edges
// (INIT, LAYERS CALC, COMPLETE) and then raises acc_rdy with the
// wrap-around sum of acc_vals. A table of single operations is applied in a
// loop. Hand-written sequences cover contention, a dropped request, reset
// in mid-operation and, in watchdog builds, the timeout abort.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_accumulator_sched;

  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int WIDTH     = 16;
  localparam int LAYERS    = 4;
  localparam int VARWIDTH  = 32;
  localparam int TIMEOUT   = 64;
  localparam int LANE_BITS = WIDTH * VARWIDTH;

  logic                           clk = 1'b0;
  logic                           rst = 1'b0;
  logic [NREQ-1:0]                req = '0;
  logic [NREQ*WIDTH*VARWIDTH-1:0] vals = '0;
  logic [NREQ-1:0]                grant;
  logic                           busy;
  logic                           done;
  logic [IDW-1:0]                 done_id;
  logic [VARWIDTH-1:0]            sum;
  logic                           err;
  logic                           acc_en;
  logic                           acc_rst;
  logic [LANE_BITS-1:0]           acc_vals;
  logic                           acc_rdy = 1'b0;
  logic [VARWIDTH-1:0]            acc_sum = '0;

  logic rdy_kill = 1'b0;
  int   acc_cnt  = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  accumulator_sched #(
    .NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .LAYERS(LAYERS),
    .VARWIDTH(VARWIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .vals(vals), .grant(grant),
    .busy(busy), .done(done), .done_id(done_id), .sum(sum), .err(err),
    .acc_en(acc_en), .acc_rst(acc_rst), .acc_vals(acc_vals),
    .acc_rdy(acc_rdy), .acc_sum(acc_sum)
  );

  // ---------------- behavioural accumulator ----------------
  function automatic logic [VARWIDTH-1:0] tree_sum(input logic [LANE_BITS-1:0] v);
    logic [VARWIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s = s + v[i*VARWIDTH +: VARWIDTH];
    return s;
  endfunction

  always @(posedge clk or posedge acc_rst) begin
    if (acc_rst) begin
      acc_cnt <= 0;
      acc_rdy <= 1'b0;
      acc_sum <= '0;
    end else if (acc_en && !acc_rdy) begin
      acc_cnt <= acc_cnt + 1;
      if (acc_cnt == LAYERS + 1) begin
        acc_rdy <= !rdy_kill;
        acc_sum <= tree_sum(acc_vals);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane i of requester k = (k+1)*base + i*stp (32-bit wrap).
  task automatic fill_vals(input logic [31:0] base, input logic [31:0] stp);
    for (int k = 0; k < NREQ; k++)
      for (int i = 0; i < WIDTH; i++)
        vals[(k*WIDTH+i)*VARWIDTH +: VARWIDTH] = base * 32'(k + 1) + stp * 32'(i);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".grant"},    64'(grant),    64'd0);
    check({tag, ".busy"},     64'(busy),     64'd0);
    check({tag, ".done"},     64'(done),     64'd0);
    check({tag, ".done_id"},  64'(done_id),  64'd0);
    check({tag, ".sum"},      64'(sum),      64'd0);
    check({tag, ".err"},      64'(err),      64'd0);
    check({tag, ".acc_en"},   64'(acc_en),   64'd0);
    check({tag, ".acc_rst"},  64'(acc_rst),  64'd1);
    check({tag, ".acc_vals"}, 64'(acc_vals === '0), 64'd1);
  endtask

  // One operation from IDLE. Call in cycle 0; req is applied at once.
  // drop_cyc >= 1 deasserts req in that cycle.
  task automatic run_op(input string tag, input logic [NREQ-1:0] r, input int exp_id,
                        input logic [31:0] exp_sum, input logic exp_err,
                        input int exp_done_cyc, input int drop_cyc);
    int cyc;
    bit seen;
    bit run_ok;
    logic [LANE_BITS-1:0] exp_lanes;
    logic [VARWIDTH-1:0]  held;
    exp_lanes = vals[exp_id*LANE_BITS +: LANE_BITS];
    req    = r;
    cyc    = 0;
    seen   = 1'b0;
    run_ok = 1'b1;
    while (!seen && cyc < exp_done_cyc + 10) begin
      step();
      cyc++;
      if (cyc == drop_cyc) req = '0;
      if (cyc == 1) begin
        check({tag, ".c1_grant"},    64'(grant),    64'(1) << exp_id);
        check({tag, ".c1_acc_rst"},  64'(acc_rst),  64'd1);
        check({tag, ".c1_acc_en"},   64'(acc_en),   64'd0);
        check({tag, ".c1_busy"},     64'(busy),     64'd1);
        check({tag, ".c1_acc_vals"}, 64'(acc_vals === exp_lanes), 64'd1);
      end else if (done !== 1'b1) begin
        if (acc_en !== 1'b1 || acc_rst !== 1'b0 || busy !== 1'b1 ||
            acc_vals !== exp_lanes) run_ok = 1'b0;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, ".done_seen"},  64'(seen),    64'd1);
    check({tag, ".done_cycle"}, 64'(cyc),     64'(exp_done_cyc));
    check({tag, ".done_id"},    64'(done_id), 64'(exp_id));
    check({tag, ".sum"},        64'(sum),     64'(exp_sum));
    check({tag, ".err"},        64'(err),     64'(exp_err));
    check({tag, ".done_grant"}, 64'(grant),   64'd0);
    check({tag, ".done_en"},    64'(acc_en),  64'd0);
    check({tag, ".run_phase"},  64'(run_ok),  64'd1);
    held = sum;
    req  = '0;
    step();
    check({tag, ".post_done"}, 64'(done), 64'd0);
    check({tag, ".post_busy"}, 64'(busy), 64'd0);
    check({tag, ".post_sum"},  64'(sum),  64'(held));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NREQ-1:0] req;
    logic [31:0]     base;
    logic [31:0]     stp;
    int              exp_id;
    logic [31:0]     exp_sum;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cyc, nd, last;
    bit ok;
    int exp_ids [5];

    // ptr starts at 3 after reset; the ids below follow the rotation.
    vecs[0] = '{4'b0001, 32'd1,          32'd1, 0, 32'd136};      // lanes 1..16
    vecs[1] = '{4'b0110, 32'd2,          32'd0, 1, 32'd64};
    vecs[2] = '{4'b0110, 32'd2,          32'd0, 2, 32'd96};
    vecs[3] = '{4'b0101, 32'd1,          32'd3, 0, 32'd376};      // wrap past 3
    vecs[4] = '{4'b1000, 32'd0,          32'd5, 3, 32'd600};
    vecs[5] = '{4'b1001, 32'd10,         32'd0, 0, 32'd160};
    vecs[6] = '{4'b1001, 32'd10,         32'd0, 3, 32'd640};
    vecs[7] = '{4'b0010, 32'h0800_0000,  32'd1, 1, 32'd120};      // sum wraps
    vecs[8] = '{4'b1111, 32'hFFFF_FFFF,  32'd0, 2, 32'hFFFF_FFD0};
    exp_ids = '{0, 1, 2, 3, 0};

    // ---- reset values ----
    rst = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b1;
    step();
    check("reset_release.acc_rst", 64'(acc_rst), 64'd0);
    check("reset_release.busy",    64'(busy),    64'd0);

    // ---- table-driven single operations ----
    for (int v = 0; v < 9; v++) begin
      fill_vals(vecs[v].base, vecs[v].stp);
      run_op($sformatf("vec%0d", v), vecs[v].req, vecs[v].exp_id,
             vecs[v].exp_sum, 1'b0, LAYERS + 5, -1);
    end

    // ---- drop during service: req 0010 deasserted in cycle 3 ----
    fill_vals(32'd4, 32'd2);
    run_op("drop", 4'b0010, 1, 32'd368, 1'b0, LAYERS + 5, 3);
    ok = 1'b1;
    repeat (12) begin
      step();
      if (grant !== '0 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    check("drop.no_regrant", 64'(ok), 64'd1);

    // ---- reset in mid-operation (rst low in cycle 5) ----
    fill_vals(32'd5, 32'd0);
    req = 4'b0100;
    ok  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (done !== 1'b0) ok = 1'b0;
    end
    check("midrst.busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    req = '0;
    step();
    check_reset_vals("midrst_c6");
    step();
    check("midrst_c7.acc_rst", 64'(acc_rst), 64'd1);
    if (done !== 1'b0) ok = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_c8.acc_rst", 64'(acc_rst), 64'd0);
    check("midrst_c8.busy",    64'(busy),    64'd0);
    if (done !== 1'b0) ok = 1'b0;
    check("midrst.no_done", 64'(ok), 64'd1);
    run_op("post_rst", 4'b1000, 3, 32'd320, 1'b0, LAYERS + 5, -1);

    // ---- contention: all four held, lanes of k = k+1 ----
    fill_vals(32'd1, 32'd0);
    req  = 4'b1111;
    cyc  = 0;
    nd   = 0;
    last = 0;
    while (nd < 5 && cyc < 80) begin
      step();
      cyc++;
      if (done === 1'b1) begin
        check($sformatf("cont%0d.done_id", nd), 64'(done_id), 64'(exp_ids[nd]));
        check($sformatf("cont%0d.sum", nd),     64'(sum),     64'(16 * (exp_ids[nd] + 1)));
        check($sformatf("cont%0d.spacing", nd), 64'(cyc - last),
              (nd == 0) ? 64'(LAYERS + 5) : 64'(LAYERS + 6));
        last = cyc;
        nd++;
        if (nd == 5) req = '0;
      end
    end
    check("cont.done_count", 64'(nd), 64'd5);
    ok = 1'b1;
    repeat (12) begin
      step();
      if (done !== 1'b0 || grant !== '0) ok = 1'b0;
    end
    check("cont.quiet_after", 64'(ok), 64'd1);

`ifdef ACC_SCHED_WATCHDOG_EN
    // ---- watchdog abort and recovery ----
    fill_vals(32'd2, 32'd1);
    rdy_kill = 1'b1;
    run_op("wd_abort", 4'b0001, 0, 32'd0, 1'b1, 2 + TIMEOUT, -1);
    rdy_kill = 1'b0;
    run_op("wd_recover", 4'b0001, 0, 32'd152, 1'b0, LAYERS + 5, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_sched.md
# accumulator_sched

Round-robin scheduler that shares one `accumulator` instance (16-lane, 32-bit, LAYERS-deep adder tree) among NREQ requesters. It grants one requester at a time and captures that requester's operand vector. It then drives the accumulator through a clear/run sequence, waits for `acc_rdy`, and returns the sum tagged with the requester index. It sits between the processing-unit lanes and the shared accumulator datapath.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, 2: requester-index width, equal to ceil(log2(NREQ)).
- `WIDTH`, 16: accumulator lane count; must match the accumulator instance.
- `LAYERS`, 4: accumulator tree depth, log2(WIDTH).
- `VARWIDTH`, 32: operand width.
- `TIMEOUT`, 64: maximum RUN cycles before abort (watchdog builds only).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req` in NREQ: request per requester; level, held until `done` carries that requester's id.
- `vals` in NREQ*WIDTH*VARWIDTH: operand vectors; requester k occupies bits [(k+1)*WIDTH*VARWIDTH-1 : k*WIDTH*VARWIDTH].
- `grant` out NREQ: one-hot; marks the requester being served.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a result is available.
- `done_id` out IDW: index of the served requester; valid while `done`=1.
- `sum` out VARWIDTH: result; valid while `done`=1; holds its value until the next `done`.
- `err` out 1: high with `done` when the operation was aborted.
- `acc_en` out 1: drives accumulator EN.
- `acc_rst` out 1: drives the accumulator's asynchronous active-high rst.
- `acc_vals` out WIDTH*VARWIDTH: drives accumulator vals; registered copy of the granted vector.
- `acc_rdy` in 1: accumulator rdy.
- `acc_sum` in VARWIDTH: accumulator sum.

## Operation
- States: IDLE, CLEAR, RUN, DONE. All outputs are registered.
- IDLE:
  - If `req` is non-zero, select the first set bit searching upward from ptr+1, wrapping modulo NREQ.
  - On that edge: set `grant`, latch the selected `vals` slice into `acc_vals`, record the index, and move to CLEAR.
- CLEAR: `acc_rst`=1 and `acc_en`=0 for exactly one cycle, then RUN.
- RUN:
  - `acc_rst`=0 and `acc_en`=1.
  - When `acc_rdy`=1 is sampled, capture `acc_sum` into `sum` and move to DONE.
- DONE:
  - `done`=1, `done_id`=index, `grant`=0, `acc_en`=0.
  - ptr takes the served index; next state is IDLE.
- Arbitration rules:
  - Dropping `req` while granted does not cancel the operation; the result is still delivered.
  - New `req` edges during service are only considered on return to IDLE.
- Reset (`rst`=0 at an edge): state IDLE, ptr=NREQ-1 (requester 0 has first priority), `grant`=0, `busy`=0, `done`=0, `done_id`=0, `sum`=0, `err`=0, `acc_en`=0, `acc_vals`=0, `acc_rst`=1.
  - `acc_rst` is held at 1 throughout reset and deasserts on the first edge after reset is released.
  - Reset mid-operation discards the operation; no `done` is produced.
- `acc_vals` is stable from CLEAR through DONE.

## Timing
- Request sampled in IDLE at cycle 0 (edge e1). CLEAR occupies cycle 1; RUN starts in cycle 2.
- Accumulator sequence: INIT at e3, LAYERS CALC edges, COMPLETE, then `acc_rdy`=1 in cycle LAYERS+4.
- `done` is high in cycle LAYERS+5 (cycle 9 for LAYERS=4).
- IDLE is re-entered in cycle LAYERS+6.
- Back-to-back grants: minimum period LAYERS+6 cycles per operation.
- IDLE dwell for a pending request is exactly one cycle.

## Configuration
- `ACC_SCHED_WATCHDOG_EN` defined:
  - A counter clears on RUN entry and increments each RUN cycle.
  - If it reaches TIMEOUT without `acc_rdy`, go to DONE with `err`=1 and `sum`=0. The next operation's CLEAR pulse recovers the accumulator.
- Not defined: no counter; RUN waits indefinitely; `err` is tied to 0.

## Test plan
- Single request, LAYERS=4:
  - Stimulus: `req`=0001, lane i of requester 0 = i+1.
  - Expected: `done` in cycle 9 with `sum`=136, `done_id`=0, `err`=0.
  - Also check the `acc_rst` pulse in cycle 1 and `acc_en` high in cycles 2-8.
- Contention:
  - Stimulus: `req`=1111 held, each requester k driving all lanes = k+1.
  - Expected: `done_id` sequence 0,1,2,3,0, sums 16,32,48,64,16, `done` pulses 10 cycles apart.
- Round-robin wrap: after serving requester 2, with `req`=0101, the next grant is requester 0.
- Drop during service:
  - Stimulus: `req`=0010 deasserted in cycle 3.
  - Expected: `done` still in cycle 9 with `done_id`=1 and the correct sum; then IDLE with no further grant.
- Reset mid-operation:
  - Stimulus: `rst`=0 in cycle 5.
  - Expected: no `done`; all outputs at reset values and `acc_rst`=1 while reset is held. A new request after release completes normally.
- Watchdog build only:
  - Stimulus: `acc_rdy` forced 0, TIMEOUT=64.
  - Expected: `done`=1 with `err`=1 and `sum`=0 after 64 RUN cycles. A following request returns the correct sum.
